// File: rtl/vector_stream_requester.sv
// Strided 128-bit vector load/store engine for a byte-enabled unaligned RAM.
// Loads are issued against a 2-entry output FIFO so rd_ready backpressure never drops data.
module vector_stream_requester #(
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [15:0]       cmd_byte_enablers,
  input  logic [127:0]      wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [127:0]      rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [127:0]      mem_data_in,
  output logic [15:0]       mem_byte_enablers,
  output logic              mem_write_enable,
  input  logic [127:0]      mem_data_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   stride_reg;
  logic [CNT_W-1:0]    remaining_reg;
  logic [15:0]         mask_reg;
  logic                done_reg, done_next;
  logic                inflight_reg;
  logic [127:0]        fifo_mem [2];
  logic                wr_ptr_reg, rd_ptr_reg;
  logic [1:0]          fifo_count_reg;

  logic                cmd_fire, write_fire, issue, advance, pop, push, last;
  logic [2:0]          occupancy;

  assign cmd_fire   = cmd_valid && (state_reg == IDLE);
  assign write_fire = (state_reg == WRITE) && wr_valid;
  assign pop        = rd_valid && rd_ready;
  assign push       = inflight_reg;
  assign last       = (remaining_reg == CNT_W'(1));
  // Slots already promised: buffered + one-cycle-old issue, minus what leaves this cycle.
  assign occupancy  = {1'b0, fifo_count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue      = (state_reg == READ) && (remaining_reg != '0) && (occupancy < 3'd2);
  assign advance    = issue || write_fire;

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_count == '0) done_next = 1'b1;
          else                 state_next = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (write_fire && last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      READ: begin
        if (issue && last) state_next = DRAIN;
      end
      DRAIN: begin
        if ((fifo_count_reg == 2'd0) && !inflight_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      done_reg       <= 1'b0;
      inflight_reg   <= 1'b0;
      addr_reg       <= '0;
      stride_reg     <= '0;
      remaining_reg  <= '0;
      mask_reg       <= '0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      fifo_count_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= done_next;
      inflight_reg <= issue;
      if (cmd_fire) begin
        addr_reg      <= cmd_base;
        stride_reg    <= cmd_stride;
        remaining_reg <= cmd_count;
        mask_reg      <= cmd_byte_enablers;
      end else if (advance) begin
        addr_reg      <= addr_reg + stride_reg;
        remaining_reg <= remaining_reg - CNT_W'(1);
      end
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 2'd1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 2'd1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by fifo_count_reg alone.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_data_out;
  end

  assign cmd_ready         = (state_reg == IDLE);
  assign wr_ready          = (state_reg == WRITE);
  assign busy              = (state_reg != IDLE);
  assign done              = done_reg;
  assign mem_address       = addr_reg;
  assign mem_data_in       = wr_data;
  assign mem_write_enable  = write_fire;
  assign mem_byte_enablers = write_fire ? mask_reg : 16'h0000;
  assign rd_valid          = (fifo_count_reg != 2'd0);
  assign rd_data           = fifo_mem[rd_ptr_reg];

endmodule

// File: tb/tb_vector_stream_requester.sv
// Randomized bench for vector_stream_requester against a byte-array RAM and an
// address/data reference computed from base + k*stride.
module tb_vector_stream_requester;
  localparam int AW = 20;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_base, cmd_stride;
  logic [CW-1:0] cmd_count;
  logic [15:0]   cmd_byte_enablers;
  logic [127:0]  wr_data;
  logic          wr_valid, wr_ready;
  logic [127:0]  rd_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] mem_address;
  logic [127:0]  mem_data_in;
  logic [15:0]   mem_byte_enablers;
  logic          mem_write_enable;
  logic [127:0]  mem_data_out;
  logic          busy, done;

  vector_stream_requester #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_count(cmd_count),
    .cmd_byte_enablers(cmd_byte_enablers),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_byte_enablers(mem_byte_enablers), .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed RAM with one-cycle registered read, wrapping at 2^AW.
  logic [7:0] ram [0:(1<<AW)-1];

  function automatic logic [127:0] ram_line(input logic [AW-1:0] a);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = ram[a + AW'(i)];
    return v;
  endfunction

  always @(posedge clock) begin : ram_proc
    logic [127:0] line;
    line = ram_line(mem_address);
    if (mem_write_enable)
      for (int i = 0; i < 16; i++)
        if (mem_byte_enablers[i]) ram[mem_address + AW'(i)] = mem_data_in[8*i +: 8];
    mem_data_out <= line;
  end

  // Current command as seen by the reference.
  logic          cur_write;
  logic [AW-1:0] cur_base, cur_stride;
  logic [15:0]   cur_mask;
  int            cur_n;
  bit            timed;
  logic [127:0]  wr_vecs [64];
  logic [127:0]  exp_rd  [64];

  int wr_idx = 0, wr_n = 0, wr_mode = 0, rd_mode = 0, ph = 0;
  bit wr_fire = 0;
  int wr_seen, rd_seen, done_cnt, done_cyc, accept_cyc, inv_bad, adv, max_occ;
  logic [AW-1:0] prev_addr;
  bit prev_valid;

  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(posedge clock); #1;
      if (wr_fire) wr_idx++;
      wr_fire  = 0;
      wr_valid = (wr_idx < wr_n) && (wr_mode == 0 || $urandom_range(0, 1) == 1);
      wr_data  = (wr_idx < wr_n) ? wr_vecs[wr_idx] : '0;
    end
  end

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (ph % 3 == 0);
        2:       rd_ready = ($urandom_range(0, 1) == 1);
        default: rd_ready = 1'b0;
      endcase
      ph++;
    end
  end

  always @(negedge clock) begin : monitor
    int occ;
    logic [AW-1:0] ea;
    if (reset) begin
      if (cmd_valid && cmd_ready) begin
        accept_cyc = cyc;
        prev_valid = 0;
      end
      if (!mem_write_enable && mem_byte_enablers != 16'h0) inv_bad++;
      if (busy == cmd_ready) inv_bad++;
      if (wr_ready != (busy && cur_write)) inv_bad++;
      if (rd_valid && cur_write) inv_bad++;
      if (!cur_write && busy && cur_stride != '0) begin
        if (prev_valid && mem_address != prev_addr) adv++;
        prev_addr  = mem_address;
        prev_valid = 1;
        occ = adv - rd_seen;
        if (occ > max_occ) max_occ = occ;
        if (occ > 2) inv_bad++;
      end
      if (mem_write_enable) begin
        if (cur_write && wr_seen < cur_n) begin
          ea = cur_base + cur_stride * AW'(wr_seen);
          check_val("wr_addr", mem_address, ea);
          check_val("wr_data", mem_data_in, wr_vecs[wr_seen]);
          check_val("wr_be", mem_byte_enablers, cur_mask);
          if (timed) check_val("wr_cyc", cyc - accept_cyc, 1 + wr_seen);
        end
        wr_seen++;
      end
      if (wr_valid && wr_ready) wr_fire = 1;
      if (rd_valid && rd_ready) begin
        if (!cur_write && rd_seen < cur_n) begin
          check_val("rd_data", rd_data, exp_rd[rd_seen]);
          if (timed) check_val("rd_cyc", cyc - accept_cyc, 3 + rd_seen);
        end
        rd_seen++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_cmd(input bit wr, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int n, input logic [15:0] mask, input int wmode, input int rmode);
    bit acc;
    @(posedge clock); #2;
    cur_write = wr; cur_base = base; cur_stride = stride; cur_n = n; cur_mask = mask;
    wr_mode = wmode; rd_mode = rmode;
    timed = (n == 0) || (wr ? (wmode == 0) : (rmode == 0));
    for (int k = 0; k < n; k++) begin
      wr_vecs[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_rd[k]  = ram_line(base + stride * AW'(k));
    end
    wr_idx = 0; wr_fire = 0; wr_n = wr ? n : 0;
    wr_seen = 0; rd_seen = 0; done_cnt = 0; done_cyc = -1; accept_cyc = -1;
    adv = 0; max_occ = 0; prev_valid = 0; inv_bad = 0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_stride = stride;
    cmd_count = CW'(n); cmd_byte_enablers = mask;
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clock);
      if (cmd_ready) acc = 1;
    end
    check_val("cmd_accept", acc, 1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string name);
    for (int t = 0; t < 500 && done_cnt == 0; t++) @(negedge clock);
    repeat (4) @(negedge clock);
    #1;
    check_val({name, ":done_cnt"}, done_cnt, 1);
    check_val({name, ":writes"}, wr_seen, cur_write ? cur_n : 0);
    check_val({name, ":beats"}, rd_seen, cur_write ? 0 : cur_n);
    check_val({name, ":inv"}, inv_bad, 0);
    if (timed)
      check_val({name, ":done_lat"}, done_cyc - accept_cyc,
                (cur_n == 0) ? 1 : (cur_write ? cur_n + 1 : cur_n + 4));
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_stride = '0;
    cmd_count = '0; cmd_byte_enablers = '0;
    cur_write = 1'b0; cur_stride = '0; cur_base = '0; cur_mask = '0; cur_n = 0; timed = 0;
    wr_seen = 0; rd_seen = 0; done_cnt = 0; done_cyc = -1; accept_cyc = -1;
    adv = 0; max_occ = 0; prev_valid = 0; inv_bad = 0; prev_addr = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom());

    repeat (3) @(posedge clock);
    #1;
    check_val("rst:cmd_ready", cmd_ready, 1);
    check_val("rst:busy", busy, 0);
    check_val("rst:wr_ready", wr_ready, 0);
    check_val("rst:rd_valid", rd_valid, 0);
    check_val("rst:mem_address", mem_address, 0);
    check_val("rst:mem_we", mem_write_enable, 0);
    check_val("rst:mem_be", mem_byte_enablers, 0);
    check_val("rst:done", done, 0);
    @(negedge clock);
    reset = 1'b1;

    start_cmd(1, 20'h00003, 20'd16, 3, 16'hFFFF, 0, 0);
    finish_cmd("store3");
    start_cmd(0, 20'h00000, 20'd16, 4, 16'h0000, 0, 0);
    finish_cmd("load4");
    start_cmd(0, 20'h00100, 20'd16, 6, 16'h0000, 0, 1);
    finish_cmd("load_bp");
    check_val("load_bp:max_buf", max_occ, 2);
    start_cmd(1, 20'hFFFF8, 20'd16, 3, 16'h5A3C, 0, 0);
    finish_cmd("store_wrap");
    start_cmd(0, 20'h00020, 20'hFFFF0, 3, 16'h0000, 0, 0);
    finish_cmd("load_neg");
    start_cmd(1, 20'h00040, 20'd16, 0, 16'hFFFF, 0, 0);
    finish_cmd("store_zero");
    start_cmd(0, 20'h00040, 20'd16, 0, 16'h0000, 0, 0);
    finish_cmd("load_zero");

    for (int r = 0; r < 20; r++) begin
      logic [AW-1:0] st;
      case ($urandom_range(0, 3))
        0:       st = 20'd16;
        1:       st = 20'hFFFF0;
        2:       st = AW'($urandom());
        default: st = AW'($urandom_range(1, 40));
      endcase
      start_cmd($urandom_range(0, 1) == 1, AW'($urandom()), st, $urandom_range(0, 6),
                16'($urandom()), $urandom_range(0, 1), $urandom_range(0, 2));
      finish_cmd($sformatf("rand%0d", r));
    end

    start_cmd(0, 20'h00200, 20'd16, 8, 16'h0000, 0, 3);
    repeat (6) @(negedge clock);
    check_val("rst_mid:buffered", rd_valid, 1);
    check_val("rst_mid:max_buf", max_occ, 2);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check_val("rst_mid:rd_valid", rd_valid, 0);
    check_val("rst_mid:cmd_ready", cmd_ready, 1);
    check_val("rst_mid:busy", busy, 0);
    check_val("rst_mid:mem_address", mem_address, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    check_val("rst_mid:no_done", done_cnt, 0);
    check_val("rst_mid:no_beat", rd_seen, 0);
    check_val("rst_mid:idle_rd_valid", rd_valid, 0);
    start_cmd(0, 20'h00300, 20'd16, 2, 16'h0000, 0, 0);
    finish_cmd("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_stream_requester.md
VECTOR_STREAM_REQUESTER -- requirements
Module: vector_stream_requester

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, byte address width toward the 128-bit byte-enabled unaligned RAM.
REQ-002 SHALL have parameter CNT_W, default 8, width of the vector-count field.
REQ-003 SHALL have port clock  in  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, and cmd_write in 1 (1=store, 0=load); together these form the command handshake.
REQ-006 SHALL have ports cmd_base in ADDR_W, cmd_stride in ADDR_W, cmd_count in CNT_W and cmd_byte_enablers in 16: start byte address, two's-complement byte stride, number of 128-bit vectors, and store byte mask.
REQ-007 SHALL have ports wr_data in 128, wr_valid in 1 and wr_ready out 1, forming the store data stream.
REQ-008 SHALL have ports rd_data out 128, rd_valid out 1 and rd_ready in 1, forming the load data stream.
REQ-009 SHALL have ports mem_address out ADDR_W, mem_data_in out 128, mem_byte_enablers out 16 and mem_write_enable out 1, driving the RAM.
REQ-010 SHALL have port mem_data_out in 128, the RAM read data, valid exactly one clock after the address is presented.
REQ-011 SHALL have ports busy out 1 and done out 1; done is a one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, READ and DRAIN.
REQ-013 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, latch base, stride, count, mask and direction, then go to WRITE (cmd_write=1) or READ (cmd_write=0).
REQ-014 SHALL, for cmd_count=0, accept the command, stay in IDLE, pulse done the next cycle, and make no RAM access.
REQ-015 SHALL drive mem_address from a registered current-address value; after each issued access, current <= current + stride, modulo 2^ADDR_W (wrap-around, negative strides allowed).
REQ-016 SHALL, in WRITE: wr_ready=1; mem_write_enable = wr_valid (combinational); mem_data_in = wr_data; mem_byte_enablers = latched mask when mem_write_enable=1, else 0.
REQ-017 SHALL, outside WRITE, hold mem_write_enable=0 and mem_byte_enablers=0.
REQ-018 SHALL decrement remaining on each write handshake; the final handshake returns the FSM to IDLE with done=1 in the following cycle.
REQ-019 SHALL, in READ, issue a read (present the address for one cycle, advance, decrement remaining) when remaining>0 and fifo_count + inflight - pop < 2, where pop = rd_valid&&rd_ready.
REQ-020 SHALL capture mem_data_out into a 2-entry FIFO on the clock edge ending the cycle after an issue; rd_valid = FIFO non-empty; rd_data = FIFO head.
REQ-021 SHALL achieve a load latency of 2 cycles from issue cycle t to rd_valid in cycle t+2, with sustained throughput of 1 vector/cycle while rd_ready=1.
REQ-022 SHALL, when remaining reaches 0 in READ, go to DRAIN; leave DRAIN when the FIFO is empty and nothing is in flight, pulse done, and enter IDLE.
REQ-023 SHALL never overflow the FIFO or drop captured data under any rd_ready pattern; a simultaneous capture and pop SHALL leave the count unchanged.
REQ-024 SHALL assert busy in every state other than IDLE.

Reset
REQ-025 SHALL, on reset low (asynchronous, including mid-operation), force: state=IDLE; cmd_ready=1; wr_ready=0; rd_valid=0; FIFO empty; inflight=0; remaining=0; mem_address=0; mem_write_enable=0; mem_byte_enablers=0; busy=0; done=0.
REQ-026 SHALL not pulse done for an operation aborted by reset; any in-flight read data is discarded.

Verification
REQ-027 Store: base=0x00003, stride=16, count=3, mask=0xFFFF, wr_valid constant -> writes at 0x00003, 0x00013, 0x00023 on consecutive cycles; done one cycle later.
REQ-028 Load with rd_ready=1: count=4 at 0x00000, stride 16 -> four rd_valid beats on consecutive cycles, first beat two cycles after the first issue; data matches the preloaded memory.
REQ-029 Load with backpressure: rd_ready toggles 1,0,0,1,... -> no beat lost or duplicated; at most 2 beats buffered; mem_address stalls while the FIFO is full.
REQ-030 Wrap and negative stride: base=0xFFFF8, stride=16 -> second access at 0x00008; stride=0xFFFF0 from 0x00020 -> 0x00010, then 0x00000.
REQ-031 cmd_count=0 -> no mem_write_enable and no rd_valid; done pulses exactly once, one cycle after acceptance.
REQ-032 Reset asserted during READ with 2 beats buffered -> rd_valid=0 immediately and cmd_ready=1; no done pulse; a new command is accepted after reset is released.
